// File: rtl/clk_div_multi_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | clk_div_multi_if : per-channel enables, divisor write port and outputs   |
// | of the multi-channel clock/tick divider. sync_in exists only when        |
// | CLKDIV_SYNC_EN is defined.                                                |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
interface clk_div_multi_if #(
   parameter int NCH   = 4,
   parameter int CNT_W = 25
);
   localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;

   logic [NCH-1:0]   en;
   logic             cfg_we;
   logic [CH_W-1:0]  cfg_ch;
   logic [CNT_W-1:0] cfg_div;
   logic [NCH-1:0]   cfg_pend;
   logic [NCH-1:0]   clk_out;
   logic [NCH-1:0]   tick;

`ifdef CLKDIV_SYNC_EN
   logic             sync_in;

   modport master (output en, cfg_we, cfg_ch, cfg_div, sync_in,
                   input  cfg_pend, clk_out, tick);
   modport slave  (input  en, cfg_we, cfg_ch, cfg_div, sync_in,
                   output cfg_pend, clk_out, tick);
`else
   modport master (output en, cfg_we, cfg_ch, cfg_div,
                   input  cfg_pend, clk_out, tick);
   modport slave  (input  en, cfg_we, cfg_ch, cfg_div,
                   output cfg_pend, clk_out, tick);
`endif
endinterface
`default_nettype wire

// File: rtl/clk_div_multi.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | clk_div_multi : NCH independent 50%-duty clock/tick generators with      |
// | shadowed half-period divisors applied only on full-period boundaries.    |
// | Optional feature macro: CLKDIV_SYNC_EN (adds sync_in phase alignment).   |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module clk_div_multi #(
   parameter int NCH     = 4,
   parameter int CNT_W   = 25,
   parameter int DIV_RST = 25_000_000
) (
   input  wire logic      clk_in,
   input  wire logic      rst_n,
   clk_div_multi_if.slave bus
);
   localparam int               CH_W      = (NCH > 1) ? $clog2(NCH) : 1;
   localparam logic [CH_W:0]    NCH_V     = (CH_W+1)'(NCH);
   localparam logic [CNT_W-1:0] DIV_RST_V = CNT_W'(DIV_RST);
   localparam logic [CNT_W-1:0] ONE_V     = CNT_W'(1);

   logic           sync;
   logic           wr_ok;
   logic [NCH-1:0] clk_v;
   logic [NCH-1:0] tick_v;
   logic [NCH-1:0] pend_v;

`ifdef CLKDIV_SYNC_EN
   assign sync = bus.sync_in;
`else
   assign sync = 1'b0;
`endif

   // Writes to a non-existent channel are dropped before the per-channel decode.
   assign wr_ok = bus.cfg_we && ({1'b0, bus.cfg_ch} < NCH_V);

   for (genvar i = 0; i < NCH; i++) begin : g_ch
      logic [CNT_W-1:0] cnt_q, cnt_d;
      logic [CNT_W-1:0] act_q, act_d;
      logic [CNT_W-1:0] shd_q, shd_d;
      logic             clk_q, clk_d;
      logic             tick_q, tick_d;
      logic             pend_q, pend_d;
      logic             wr;
      logic             term;
      logic [CNT_W-1:0] de;

      assign wr   = wr_ok && (bus.cfg_ch == CH_W'(i));
      assign de   = (act_q == '0) ? ONE_V : act_q;
      assign term = (cnt_q == (de - ONE_V));

      always_comb begin
         cnt_d  = cnt_q;
         clk_d  = clk_q;
         tick_d = 1'b0;
         act_d  = act_q;
         shd_d  = shd_q;
         pend_d = pend_q;
         if (sync || !bus.en[i]) begin
            cnt_d = '0;
            clk_d = 1'b0;
            if (pend_q) begin
               act_d  = shd_q;
               pend_d = 1'b0;
            end
         end else if (term) begin
            cnt_d  = '0;
            clk_d  = ~clk_q;
            tick_d = ~clk_q;
            // Only the falling toggle closes a full period; swap divisors there.
            if (clk_q && pend_q) begin
               act_d  = shd_q;
               pend_d = 1'b0;
            end
         end else begin
            cnt_d = cnt_q + ONE_V;
         end
         // A same-cycle write lands after any apply, so it stays pending.
         if (wr) begin
            shd_d  = bus.cfg_div;
            pend_d = 1'b1;
         end
      end

      always_ff @(posedge clk_in or negedge rst_n) begin
         if (!rst_n) begin
            cnt_q  <= '0;
            act_q  <= DIV_RST_V;
            shd_q  <= '0;
            clk_q  <= 1'b0;
            tick_q <= 1'b0;
            pend_q <= 1'b0;
         end else begin
            cnt_q  <= cnt_d;
            act_q  <= act_d;
            shd_q  <= shd_d;
            clk_q  <= clk_d;
            tick_q <= tick_d;
            pend_q <= pend_d;
         end
      end

      assign clk_v[i]  = clk_q;
      assign tick_v[i] = tick_q;
      assign pend_v[i] = pend_q;
   end

   assign bus.clk_out  = clk_v;
   assign bus.tick     = tick_v;
   assign bus.cfg_pend = pend_v;
endmodule
`default_nettype wire

// File: tb/tb_clk_div_multi.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_clk_div_multi : scoreboard bench for clk_div_multi (NCH=4, DIV_RST=3, |
// | plus a 3-channel instance for out-of-range channel writes).              |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_clk_div_multi;
   logic clk_in = 1'b0;
   logic rst_n  = 1'b1;
   always #5 clk_in = ~clk_in;

   clk_div_multi_if #(.NCH(4), .CNT_W(8)) bus  ();
   clk_div_multi_if #(.NCH(3), .CNT_W(8)) bus3 ();

   clk_div_multi #(.NCH(4), .CNT_W(8), .DIV_RST(3)) dut (
      .clk_in(clk_in), .rst_n(rst_n), .bus(bus));
   clk_div_multi #(.NCH(3), .CNT_W(8), .DIV_RST(3)) dut3 (
      .clk_in(clk_in), .rst_n(rst_n), .bus(bus3));

   typedef struct {
      logic [3:0] clk;
      logic [3:0] tick;
      logic [3:0] pend;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   // Ideal waveform n edges after a channel starts from cnt=0, clk_out=0.
   function automatic logic wv_clk(int n, int d);
      return ((n / d) % 2) == 1;
   endfunction
   function automatic logic wv_tick(int n, int d);
      return (n > 0) && ((n % (2 * d)) == d);
   endfunction
   function automatic logic [3:0] at(int ch, logic b);
      logic [3:0] v;
      v = '0;
      v[ch] = b;
      return v;
   endfunction

   task automatic idle_inputs();
      bus.en = '0;  bus.cfg_we = 1'b0;  bus.cfg_ch = '0;  bus.cfg_div = '0;
      bus3.en = '0; bus3.cfg_we = 1'b0; bus3.cfg_ch = '0; bus3.cfg_div = '0;
`ifdef CLKDIV_SYNC_EN
      bus.sync_in = 1'b0; bus3.sync_in = 1'b0;
`endif
   endtask

   task automatic do_reset();
      idle_inputs();
      rst_n = 1'b0;
      repeat (2) @(posedge clk_in);
      #1 rst_n = 1'b1;
   endtask

   task automatic test_reset();
      idle_inputs();
      #2 rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({bus.clk_out, bus.tick, bus.cfg_pend} !== 12'h000) begin
         n_bad++;
         $display("FAIL reset4 clk/tick/pend got %b/%b/%b want 0000/0000/0000",
                  bus.clk_out, bus.tick, bus.cfg_pend);
      end
      n_cmp++;
      if ({bus3.clk_out, bus3.tick, bus3.cfg_pend} !== 9'h000) begin
         n_bad++;
         $display("FAIL reset3 clk/tick/pend got %b/%b/%b want 000/000/000",
                  bus3.clk_out, bus3.tick, bus3.cfg_pend);
      end
      do_reset();
   endtask

   task automatic test_free_run();
      exp_t e;
      do_reset();
      bus.en = 4'hF;
      for (int n = 1; n <= 24; n++)
         sb.push_back('{clk: {4{wv_clk(n, 3)}}, tick: {4{wv_tick(n, 3)}}, pend: 4'h0});
      for (int n = 1; n <= 24; n++) begin
         @(posedge clk_in); #1;
         n_cmp++;
         e = sb.pop_front();
         if ({bus.clk_out, bus.tick, bus.cfg_pend} !== {e.clk, e.tick, e.pend}) begin
            n_bad++;
            $display("FAIL free_run n=%0d clk/tick/pend got %b/%b/%b want %b/%b/%b",
                     n, bus.clk_out, bus.tick, bus.cfg_pend, e.clk, e.tick, e.pend);
         end
      end
   endtask

   task automatic test_div_change();
      exp_t e;
      int   m, d;
      do_reset();
      bus.en = 4'b0010;
      for (int n = 1; n <= 26; n++) begin
         m = (n <= 6) ? n : n - 6;
         d = (n <= 6) ? 3 : 5;
         sb.push_back('{clk: at(1, wv_clk(m, d)), tick: at(1, wv_tick(m, d)),
                        pend: at(1, (n == 4) || (n == 5))});
      end
      for (int n = 1; n <= 26; n++) begin
         @(posedge clk_in); #1;
         n_cmp++;
         e = sb.pop_front();
         if ({bus.clk_out, bus.tick, bus.cfg_pend} !== {e.clk, e.tick, e.pend}) begin
            n_bad++;
            $display("FAIL div_change n=%0d clk/tick/pend got %b/%b/%b want %b/%b/%b",
                     n, bus.clk_out, bus.tick, bus.cfg_pend, e.clk, e.tick, e.pend);
         end
         if (n == 3) begin bus.cfg_we = 1'b1; bus.cfg_ch = 2'd1; bus.cfg_div = 8'd5; end
         if (n == 4) bus.cfg_we = 1'b0;
      end
   endtask

   task automatic test_div_zero();
      exp_t e;
      int   m, d;
      do_reset();
      bus.en = 4'b0100;
      bus.cfg_we = 1'b1; bus.cfg_ch = 2'd2; bus.cfg_div = 8'd9;
      for (int n = 1; n <= 16; n++) begin
         m = (n <= 6) ? n : n - 6;
         d = (n <= 6) ? 3 : 1;
         sb.push_back('{clk: at(2, wv_clk(m, d)), tick: at(2, wv_tick(m, d)),
                        pend: at(2, n <= 5)});
      end
      for (int n = 1; n <= 16; n++) begin
         @(posedge clk_in); #1;
         n_cmp++;
         e = sb.pop_front();
         if ({bus.clk_out, bus.tick, bus.cfg_pend} !== {e.clk, e.tick, e.pend}) begin
            n_bad++;
            $display("FAIL div_zero n=%0d clk/tick/pend got %b/%b/%b want %b/%b/%b",
                     n, bus.clk_out, bus.tick, bus.cfg_pend, e.clk, e.tick, e.pend);
         end
         if (n == 1) bus.cfg_div = 8'd0;
         if (n == 2) bus.cfg_we  = 1'b0;
      end
   endtask

   task automatic test_enable_drop();
      exp_t e;
      logic c, t;
      do_reset();
      bus.en = 4'b0001;
      for (int n = 1; n <= 18; n++) begin
         if (n <= 4)      begin c = wv_clk(n, 3);     t = wv_tick(n, 3);     end
         else if (n <= 7) begin c = 1'b0;             t = 1'b0;              end
         else             begin c = wv_clk(n - 7, 2); t = wv_tick(n - 7, 2); end
         sb.push_back('{clk: at(0, c), tick: at(0, t), pend: at(0, n == 6)});
      end
      for (int n = 1; n <= 18; n++) begin
         @(posedge clk_in); #1;
         n_cmp++;
         e = sb.pop_front();
         if ({bus.clk_out, bus.tick, bus.cfg_pend} !== {e.clk, e.tick, e.pend}) begin
            n_bad++;
            $display("FAIL enable_drop n=%0d clk/tick/pend got %b/%b/%b want %b/%b/%b",
                     n, bus.clk_out, bus.tick, bus.cfg_pend, e.clk, e.tick, e.pend);
         end
         if (n == 4) bus.en = 4'b0000;
         if (n == 5) begin bus.cfg_we = 1'b1; bus.cfg_ch = 2'd0; bus.cfg_div = 8'd2; end
         if (n == 6) bus.cfg_we = 1'b0;
         if (n == 7) bus.en = 4'b0001;
      end
   endtask

   task automatic test_cfg_range();
      exp_t e;
      do_reset();
      bus3.cfg_we = 1'b1; bus3.cfg_ch = 2'd3; bus3.cfg_div = 8'd1;
      sb.push_back('{clk: 4'h0, tick: 4'h0, pend: 4'b0000});
      sb.push_back('{clk: 4'h0, tick: 4'h0, pend: 4'b0100});
      sb.push_back('{clk: 4'h0, tick: 4'h0, pend: 4'b0000});
      sb.push_back('{clk: 4'h0, tick: 4'h0, pend: 4'b0000});
      for (int n = 1; n <= 4; n++) begin
         @(posedge clk_in); #1;
         n_cmp++;
         e = sb.pop_front();
         if ({1'b0, bus3.clk_out, 1'b0, bus3.tick, 1'b0, bus3.cfg_pend} !== {e.clk, e.tick, e.pend}) begin
            n_bad++;
            $display("FAIL cfg_range n=%0d clk/tick/pend got %b/%b/%b want %b/%b/%b",
                     n, bus3.clk_out, bus3.tick, bus3.cfg_pend, e.clk, e.tick, e.pend);
         end
         if (n == 1) bus3.cfg_ch = 2'd2;
         if (n == 2) bus3.cfg_we = 1'b0;
      end
   endtask

   task automatic test_back_to_back();
      exp_t e;
      int   m, d;
      do_reset();
      bus.en = 4'b1000;
      bus.cfg_we = 1'b1; bus.cfg_ch = 2'd3; bus.cfg_div = 8'd4;
      for (int n = 1; n <= 30; n++) begin
         if (n <= 6)       begin m = n;      d = 3; end
         else if (n <= 14) begin m = n - 6;  d = 4; end
         else              begin m = n - 14; d = 7; end
         sb.push_back('{clk: at(3, wv_clk(m, d)), tick: at(3, wv_tick(m, d)),
                        pend: at(3, n <= 13)});
      end
      for (int n = 1; n <= 30; n++) begin
         @(posedge clk_in); #1;
         n_cmp++;
         e = sb.pop_front();
         if ({bus.clk_out, bus.tick, bus.cfg_pend} !== {e.clk, e.tick, e.pend}) begin
            n_bad++;
            $display("FAIL back_to_back n=%0d clk/tick/pend got %b/%b/%b want %b/%b/%b",
                     n, bus.clk_out, bus.tick, bus.cfg_pend, e.clk, e.tick, e.pend);
         end
         if (n == 1) bus.cfg_we = 1'b0;
         if (n == 5) begin bus.cfg_we = 1'b1; bus.cfg_div = 8'd7; end
         if (n == 6) bus.cfg_we = 1'b0;
      end
   endtask

   task automatic test_mid_reset();
      exp_t e;
      do_reset();
      bus.en = 4'hF;
      bus.cfg_we = 1'b1; bus.cfg_ch = 2'd0; bus.cfg_div = 8'd6;
      for (int n = 1; n <= 4; n++) begin
         @(posedge clk_in); #1;
         bus.cfg_we = 1'b0;
      end
      #3 rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({bus.clk_out, bus.tick, bus.cfg_pend} !== 12'h000) begin
         n_bad++;
         $display("FAIL mid_reset clk/tick/pend got %b/%b/%b want 0000/0000/0000",
                  bus.clk_out, bus.tick, bus.cfg_pend);
      end
      @(posedge clk_in);
      #1 rst_n = 1'b1;
      for (int n = 1; n <= 14; n++)
         sb.push_back('{clk: {4{wv_clk(n, 3)}}, tick: {4{wv_tick(n, 3)}}, pend: 4'h0});
      for (int n = 1; n <= 14; n++) begin
         @(posedge clk_in); #1;
         n_cmp++;
         e = sb.pop_front();
         if ({bus.clk_out, bus.tick, bus.cfg_pend} !== {e.clk, e.tick, e.pend}) begin
            n_bad++;
            $display("FAIL after_reset n=%0d clk/tick/pend got %b/%b/%b want %b/%b/%b",
                     n, bus.clk_out, bus.tick, bus.cfg_pend, e.clk, e.tick, e.pend);
         end
      end
   endtask

`ifdef CLKDIV_SYNC_EN
   task automatic test_sync();
      exp_t e;
      do_reset();
      bus.cfg_we = 1'b1; bus.cfg_ch = 2'd1; bus.cfg_div = 8'd4;
      for (int k = 1; k <= 11; k++) begin
         @(posedge clk_in); #1;
         if (k == 1)  begin bus.cfg_ch = 2'd2; bus.cfg_div = 8'd5; end
         if (k == 2)  bus.cfg_we = 1'b0;
         if (k == 3)  bus.en = 4'b0001;
         if (k == 5)  bus.en = 4'b0011;
         if (k == 6)  bus.en = 4'b0111;
         if (k == 11) bus.sync_in = 1'b1;
      end
      for (int n = 0; n <= 15; n++)
         sb.push_back('{clk:  {1'b0, wv_clk(n, 5), wv_clk(n, 4), wv_clk(n, 3)},
                        tick: {1'b0, wv_tick(n, 5), wv_tick(n, 4), wv_tick(n, 3)},
                        pend: 4'h0});
      for (int n = 0; n <= 15; n++) begin
         @(posedge clk_in); #1;
         n_cmp++;
         e = sb.pop_front();
         if ({bus.clk_out, bus.tick, bus.cfg_pend} !== {e.clk, e.tick, e.pend}) begin
            n_bad++;
            $display("FAIL sync n=%0d clk/tick/pend got %b/%b/%b want %b/%b/%b",
                     n, bus.clk_out, bus.tick, bus.cfg_pend, e.clk, e.tick, e.pend);
         end
         if (n == 0) bus.sync_in = 1'b0;
      end
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached with %0d compared", n_cmp);
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_free_run();
      test_div_change();
      test_div_zero();
      test_enable_drop();
      test_cfg_range();
      test_back_to_back();
      test_mid_reset();
`ifdef CLKDIV_SYNC_EN
      test_sync();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
`default_nettype wire
